matrix_uart_loader: RTL

// Frame decoder between the UART byte receiver and the 16x16 matrix memory.

---
 rtl/matrix_pkg.sv | 20 ++
 rtl/matrix_uart_loader_if.sv | 10 +
 rtl/loader_timeout.sv | 33 +++
 rtl/matrix_uart_loader.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types for the UART-to-matrix frame loader: FSM states, error causes
// and the default frame start marker.
package matrix_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CHECK
  } loader_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_CSUM    = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_RX      = 2'b11
  } err_code_e;

endpackage

// File: rtl/matrix_uart_loader_if.sv
// Byte stream from the UART receiver: data with a valid strobe and a
// framing-error strobe. The receiver is master, the loader is slave.
interface matrix_uart_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;

  modport master (output rx_data, output rx_valid, output rx_err);
  modport slave  (input  rx_data, input  rx_valid, input  rx_err);
endinterface

// File: rtl/loader_timeout.sv
// Inter-byte watchdog: reload arms a CYCLES-long window; o_expired rises in
// the CYCLES-th cycle after the reload if no further reload has arrived.
module loader_timeout #(
  parameter int CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_reload,
  input  logic i_run,
  output logic o_expired
);

  localparam int              CW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0]   LOAD = CW'(CYCLES - 1);

  logic [CW-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_reload) begin
      r_count <= LOAD;
    end else if (i_run && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  // Saturates at zero, so expiry stays asserted until the FSM leaves the frame.
  assign o_expired = i_run && (r_count == '0);

endmodule

// File: rtl/matrix_uart_loader.sv
// Frame decoder: sync byte, DEPTH payload bytes written to consecutive
// addresses, then an 8-bit additive checksum. All outputs are registered.
module matrix_uart_loader
  import matrix_pkg::*;
#(
  parameter int         ADDR_WIDTH     = 8,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  matrix_uart_loader_if.slave   rx,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [7:0]            mem_wdata,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic [1:0]            err_code,
  output logic                  matrix_valid
);

  localparam int            DEPTH    = 1 << ADDR_WIDTH;
  localparam int            CW       = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

  loader_state_e r_state, w_next;

  logic [CW-1:0]         r_count;
  logic [7:0]            r_sum;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [7:0]            r_wdata;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  err_code_e             r_err_code;
  logic                  r_matrix_valid;

  logic      w_start;
  logic      w_write;
  logic      w_done;
  logic      w_fail;
  err_code_e w_fail_code;
  logic      w_expired;

  loader_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_reload  (w_start | w_write),
    .i_run     (r_state != IDLE),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Priority inside a frame: rx_err, then rx_valid, then watchdog expiry.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    w_next      = r_state;
    w_start     = 1'b0;
    w_write     = 1'b0;
    w_done      = 1'b0;
    w_fail      = 1'b0;
    w_fail_code = ERR_NONE;
    case (r_state)
      IDLE: begin
        if (rx.rx_valid && !rx.rx_err && (rx.rx_data == SYNC_BYTE)) begin
          w_next  = PAYLOAD;
          w_start = 1'b1;
        end
      end
      PAYLOAD: begin
        if (rx.rx_err) begin
          w_next      = IDLE;
          w_fail      = 1'b1;
          w_fail_code = ERR_RX;
        end else if (rx.rx_valid) begin
          w_write = 1'b1;
          if (r_count == LAST_IDX) w_next = CHECK;
        end else if (w_expired) begin
          w_next      = IDLE;
          w_fail      = 1'b1;
          w_fail_code = ERR_TIMEOUT;
        end
      end
      CHECK: begin
        if (rx.rx_err) begin
          w_next      = IDLE;
          w_fail      = 1'b1;
          w_fail_code = ERR_RX;
        end else if (rx.rx_valid) begin
          w_next = IDLE;
          if (rx.rx_data == r_sum) begin
            w_done = 1'b1;
          end else begin
            w_fail      = 1'b1;
            w_fail_code = ERR_CSUM;
          end
        end else if (w_expired) begin
          w_next      = IDLE;
          w_fail      = 1'b1;
          w_fail_code = ERR_TIMEOUT;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count        <= '0;
      r_sum          <= '0;
      r_we           <= 1'b0;
      r_waddr        <= '0;
      r_wdata        <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_err_code     <= ERR_NONE;
      r_matrix_valid <= 1'b0;
    end else begin
      r_we   <= w_write;
      r_busy <= (w_next != IDLE);
      r_done <= w_done;
      r_err  <= w_fail;
      if (w_fail) r_err_code <= w_fail_code;
      if (w_start) begin
        r_count        <= '0;
        r_sum          <= '0;
        r_matrix_valid <= 1'b0;
      end
      if (w_write) begin
        r_waddr <= r_count[ADDR_WIDTH-1:0];
        r_wdata <= rx.rx_data;
        r_count <= r_count + CW'(1);
        r_sum   <= r_sum + rx.rx_data;
      end
      if (w_done) r_matrix_valid <= 1'b1;
    end
  end

  assign mem_we       = r_we;
  assign mem_waddr    = r_waddr;
  assign mem_wdata    = r_wdata;
  assign busy         = r_busy;
  assign frame_done   = r_done;
  assign frame_err    = r_err;
  assign err_code     = r_err_code;
  assign matrix_valid = r_matrix_valid;

endmodule
